// File: rtl/sound_source_arbiter.sv
// rtl/sound_source_arbiter.sv - round-robin owner of the shared audio sample path
// Generates the sample tick, grants one source at a time with a minimum quantum, latches its sample.
module sound_source_arbiter #(
  parameter int clk_mhz        = 27,
  parameter int sample_rate_hz = 48000,
  parameter int n_src          = 4,
  parameter int w_sample       = 16,
  parameter int quantum_ticks  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [n_src-1:0]          req,
  input  logic [n_src*w_sample-1:0] sample_in,
  output logic [n_src-1:0]          grant,
  output logic [n_src-1:0]          ack,
  output logic [w_sample-1:0]       sound,
  output logic                      sample_tick,
  output logic                      busy
);

  localparam int period = (clk_mhz * 1000000) / sample_rate_hz;
  localparam int tick_w = $clog2(period + 1);
  localparam int cnt_w  = $clog2(quantum_ticks + 1);
  localparam int idx_w  = (n_src > 1) ? $clog2(n_src) : 1;
  localparam int iw1    = idx_w + 1;

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_own  = 1'b1;

  logic [tick_w-1:0] tick_cnt;
  logic [0:0]        state;
  logic [idx_w-1:0]  owner;
  logic [idx_w-1:0]  last_owner;
  logic [cnt_w-1:0]  own_cnt;

  logic              tick;
  logic              owner_req;
  logic              take;
  logic              others;
  logic [idx_w-1:0]  idle_pick;
  logic [idx_w-1:0]  rot_pick;

  // First set bit of mask scanning from base+1 upward, wrapping modulo n_src.
  function automatic logic [idx_w-1:0] rr_pick(input logic [n_src-1:0] mask,
                                               input logic [idx_w-1:0] base);
    logic [idx_w-1:0] sel;
    logic             found;
    logic [iw1-1:0]   s;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= n_src; k++) begin
      s = {1'b0, base} + iw1'(k);
      if (s >= iw1'(n_src)) s = s - iw1'(n_src);
      if (!found && mask[s[idx_w-1:0]]) begin
        sel   = s[idx_w-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [n_src-1:0] onehot(input logic [idx_w-1:0] i);
    return {{(n_src-1){1'b0}}, 1'b1} << i;
  endfunction

  always_comb begin
    tick      = (tick_cnt == tick_w'(period - 1));
    owner_req = req[owner];
    take      = (state == st_own) && tick && owner_req;
    others    = |(req & ~grant);
    idle_pick = rr_pick(req, last_owner);
    rot_pick  = rr_pick(req & ~grant, owner);
    ack       = take ? grant : '0;
    sample_tick = tick;
    busy      = |grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt   <= '0;
      state      <= st_idle;
      owner      <= '0;
      last_owner <= idx_w'(n_src - 1);
      own_cnt    <= '0;
      grant      <= '0;
      sound      <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + tick_w'(1);
      if (tick) sound <= take ? sample_in[owner*w_sample +: w_sample] : '0;

      case (state)
        st_idle: begin
          if (|req) begin
            state   <= st_own;
            owner   <= idle_pick;
            grant   <= onehot(idle_pick);
            own_cnt <= '0;
          end
        end
        default: begin
          if (!owner_req) begin
            state      <= st_idle;
            grant      <= '0;
            last_owner <= owner;
          end else if (take) begin
            // Saturated counter means the quantum is spent; hand over at the first tick a rival waits.
            if (own_cnt >= cnt_w'(quantum_ticks - 1) && others) begin
              last_owner <= owner;
              owner      <= rot_pick;
              grant      <= onehot(rot_pick);
              own_cnt    <= '0;
            end else if (own_cnt != cnt_w'(quantum_ticks)) begin
              own_cnt <= own_cnt + cnt_w'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_source_arbiter.sv
// tb/tb_sound_source_arbiter.sv - directed and random checks against a tick-level reference model
module tb_sound_source_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int Q = 3;
  localparam int P = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] sample_in;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic [W-1:0]   sound;
  logic           sample_tick;
  logic           busy;

  sound_source_arbiter #(
    .clk_mhz(1), .sample_rate_hz(100000), .n_src(N), .w_sample(W), .quantum_ticks(Q)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .sample_in(sample_in), .grant(grant),
    .ack(ack), .sound(sound), .sample_tick(sample_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: phase within the sample period, current owner (-1 none), ticks served.
  int           m_cyc;
  int           m_owner;
  int           m_last;
  int           m_served;
  logic [W-1:0] m_sound;
  int           n_ticks;
  int           acks;
  int           idx;
  int           hits;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int base, input int excl);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (base + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_owner = -1; m_last = N - 1; m_served = 0; m_sound = '0;
  endtask

  task automatic model_update();
    logic tk;
    logic served;
    int   j;
    if (rst) begin
      model_reset();
      return;
    end
    tk     = (m_cyc == P - 1);
    served = tk && m_owner >= 0 && req[m_owner];
    if (tk) m_sound = served ? sample_in[m_owner*W +: W] : '0;
    m_cyc = (m_cyc + 1) % P;
    if (m_owner < 0) begin
      j = pick(req, m_last, -1);
      if (j >= 0) begin m_owner = j; m_served = 0; end
    end else if (!req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (served) begin
      m_served++;
      j = pick(req, m_owner, m_owner);
      if (m_served >= Q && j >= 0) begin
        m_last = m_owner; m_owner = j; m_served = 0;
      end else if (m_served > Q) begin
        m_served = Q;
      end
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    logic [N-1:0] e_grant;
    logic         e_tick;
    #1;
    e_grant = (m_owner < 0) ? '0 : N'(1) << m_owner;
    e_tick  = (m_cyc == P - 1);
    chk("grant", grant, e_grant);
    chk("ack", ack, (e_tick && m_owner >= 0 && req[m_owner]) ? e_grant : '0);
    chk("sound", sound, m_sound);
    chk("sample_tick", sample_tick, e_tick);
    chk("busy", busy, m_owner >= 0);
    if (sample_tick === 1'b1) n_ticks++;
    model_update();
    @(negedge clk);
  endtask

  task automatic to_tick();
    int guard;
    guard = 0;
    while (m_cyc != P - 1 && guard < 2 * P) begin
      step();
      guard++;
    end
    if (guard >= 2 * P) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_sample(input int i, input logic [W-1:0] v);
    sample_in[i*W +: W] = v;
  endtask

  initial begin
    rst = 1'b1; req = '0; sample_in = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Idle ticking: ticks at cycles 9,19,29,39,49
    n_ticks = 0;
    repeat (50) step();
    chk("t1_tick_count", n_ticks, 5);

    // Single source grant, sample, release
    set_sample(0, 16'h1234);
    req = 4'b0001;
    step();
    #1 chk("t2_grant", grant, 4'b0001);
    to_tick();
    #1 chk("t2_ack", ack, 4'b0001);
    step();
    #1 chk("t2_sound", sound, 16'h1234);
    req = 4'b0000;
    step();
    #1 chk("t2_release", grant, 4'b0000);
    to_tick();
    #1 chk("t2_idle_ack", ack, 4'b0000);
    step();
    #1 chk("t2_idle_sound", sound, 16'h0000);

    // Two requesters rotate after the quantum
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_sample(1, 16'h1111); set_sample(3, 16'h3333);
    req = 4'b1010;
    step();
    #1 chk("t3_first", grant, 4'b0010);
    repeat (3) begin to_tick(); step(); end
    #1 chk("t3_rotate", grant, 4'b1000);
    repeat (3) begin to_tick(); step(); end
    #1 chk("t3_back", grant, 4'b0010);

    // Lone owner keeps the grant, then yields once a rival appears
    set_sample(2, 16'hbeef); set_sample(0, 16'h0a0a);
    req = 4'b0100;
    step(); step();
    #1 chk("t4_grant", grant, 4'b0100);
    acks = 0;
    repeat (20) begin
      to_tick();
      #1 if (ack === 4'b0100) acks++;
      step();
    end
    chk("t4_acks", acks, 20);
    #1 chk("t4_hold", grant, 4'b0100);
    req = 4'b0101;
    to_tick();
    step();
    #1 chk("t4_yield", grant, 4'b0001);

    // Owner drops its request in the tick cycle
    step();
    to_tick();
    req = 4'b0000;
    #1 chk("t5_ack", ack, 4'b0000);
    step();
    #1 chk("t5_sound", sound, 16'h0000);
    chk("t5_grant", grant, 4'b0000);

    // Reset mid-period while owning
    req = 4'b0010;
    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0110;
    #1 chk("t6_outputs", {grant, ack, sound, sample_tick, busy}, '0);
    step();
    #1 chk("t6_regrant", grant, 4'b0010);
    idx = 1; hits = 0;
    while (idx < 20 && hits == 0) begin
      #1 if (sample_tick === 1'b1) hits = idx;
      step();
      idx++;
    end
    chk("t6_tick_phase", hits, 9);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) req[$urandom_range(0, N - 1)] ^= 1'b1;
      sample_in = {$urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
